// File: rtl/sdram_init_monitor.sv
// rtl/sdram_init_monitor.sv - SDRAM power-up sequence checker with mode register capture
module sdram_init_monitor #(
  parameter int SDRAM_ROW    = 13,
  parameter int tINIT_CYCLE  = 20000,
  parameter int tRP_CYCLE    = 3,
  parameter int tRFC_CYCLE   = 7,
  parameter int tMRD_CYCLE   = 2,
  parameter int INIT_REF_CNT = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sdram_cke,
  input  logic                 sdram_cs_n,
  input  logic                 sdram_ras_n,
  input  logic                 sdram_cas_n,
  input  logic                 sdram_we_n,
  input  logic [SDRAM_ROW-1:0] sdram_addr,
  output logic                 init_ok,
  output logic                 init_err,
  output logic [2:0]           err_code,
  output logic [2:0]           mr_burst_length,
  output logic                 mr_burst_type,
  output logic [2:0]           mr_cas_latency,
  output logic                 mr_write_burst_mode
);

  localparam int MAX_A = (tINIT_CYCLE > tRP_CYCLE) ? tINIT_CYCLE : tRP_CYCLE;
  localparam int MAX_B = (tRFC_CYCLE > tMRD_CYCLE) ? tRFC_CYCLE : tMRD_CYCLE;
  localparam int MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int GAP_W = $clog2(MAX_T) + 1;
  localparam int REF_W = (INIT_REF_CNT < 1) ? 1 : $clog2(INIT_REF_CNT + 1);

  localparam logic [GAP_W-1:0] INIT_MIN = GAP_W'(tINIT_CYCLE - 1);
  localparam logic [GAP_W-1:0] RP_MIN   = GAP_W'(tRP_CYCLE - 1);
  localparam logic [GAP_W-1:0] RFC_MIN  = GAP_W'(tRFC_CYCLE - 1);
  localparam logic [GAP_W-1:0] MRD_MIN  = GAP_W'(tMRD_CYCLE - 1);
  localparam logic [REF_W-1:0] REF_MIN  = REF_W'(INIT_REF_CNT);

  typedef enum logic [6:0] {
    S_WAIT_CKE  = 7'b0000001,
    S_POWER_UP  = 7'b0000010,
    S_PRECHARGE = 7'b0000100,
    S_REFRESH   = 7'b0001000,
    S_LMR       = 7'b0010000,
    S_DONE      = 7'b0100000,
    S_ERROR     = 7'b1000000
  } state_t;

  state_t             state;
  logic [GAP_W-1:0]   gap;
  logic [REF_W-1:0]   ref_cnt;
  logic [3:0]         cmd;
  logic               is_idle, is_pre, is_ref, is_lmr, is_illegal;
  logic               checking;
  logic [2:0]         err_det;
  logic               unused_addr;

  assign cmd        = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
  assign is_idle    = sdram_cs_n || (cmd == 4'b0111);
  assign is_pre     = (cmd == 4'b0010);
  assign is_ref     = (cmd == 4'b0001);
  assign is_lmr     = (cmd == 4'b0000);
  assign is_illegal = !is_idle && !is_pre && !is_ref && !is_lmr;
  assign checking   = (state == S_POWER_UP) || (state == S_PRECHARGE) ||
                      (state == S_REFRESH) || (state == S_LMR);
  assign unused_addr = ^sdram_addr;

  // Illegal opcodes and CKE drops outrank the per-state timing checks.
  always_comb begin
    err_det = 3'd0;
    if (checking) begin
      if (is_illegal || !sdram_cke) begin
        err_det = 3'd6;
      end else begin
        case (state)
          S_POWER_UP: begin
            if (is_pre) begin
              if (gap < INIT_MIN)        err_det = 3'd1;
              else if (!sdram_addr[10])  err_det = 3'd2;
            end else if (!is_idle) begin
              err_det = 3'd1;
            end
          end
          S_PRECHARGE: begin
            if (!is_idle && !(is_ref && gap >= RP_MIN)) err_det = 3'd3;
          end
          S_REFRESH: begin
            if (!is_idle) begin
              if (gap < RFC_MIN)                    err_det = 3'd4;
              else if (is_ref)                      err_det = 3'd0;
              else if (is_lmr && ref_cnt < REF_MIN) err_det = 3'd5;
              else if (!is_lmr)                     err_det = 3'd6;
            end
          end
          S_LMR: begin
            if (!is_idle && gap < MRD_MIN) err_det = 3'd7;
          end
          default: err_det = 3'd0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= S_WAIT_CKE;
      gap                 <= '0;
      ref_cnt             <= '0;
      init_ok             <= 1'b0;
      init_err            <= 1'b0;
      err_code            <= 3'd0;
      mr_burst_length     <= 3'd0;
      mr_burst_type       <= 1'b0;
      mr_cas_latency      <= 3'd0;
      mr_write_burst_mode <= 1'b0;
    end else begin
      if ((state == S_WAIT_CKE && sdram_cke) || !is_idle)
        gap <= '0;
      else if (gap != '1)
        gap <= gap + 1'b1;

      if (err_det != 3'd0) begin
        state    <= S_ERROR;
        init_err <= 1'b1;
        err_code <= err_det;
      end else begin
        case (state)
          S_WAIT_CKE:  if (sdram_cke) state <= S_POWER_UP;
          S_POWER_UP:  if (is_pre) state <= S_PRECHARGE;
          S_PRECHARGE: begin
            if (is_ref) begin
              if (ref_cnt < REF_MIN) ref_cnt <= ref_cnt + 1'b1;
              state <= S_REFRESH;
            end
          end
          S_REFRESH: begin
            if (is_ref && ref_cnt < REF_MIN) ref_cnt <= ref_cnt + 1'b1;
            if (is_lmr) begin
              mr_burst_length     <= sdram_addr[2:0];
              mr_burst_type       <= sdram_addr[3];
              mr_cas_latency      <= sdram_addr[6:4];
              mr_write_burst_mode <= sdram_addr[9];
              state               <= S_LMR;
            end
          end
          S_LMR: begin
            if (gap >= MRD_MIN) begin
              state   <= S_DONE;
              init_ok <= 1'b1;
            end
          end
          default: state <= state;
        endcase
      end
    end
  end

endmodule
